// File: rtl/rx_fifo_sequencer_pkg.sv
// Shared state encoding, defaults and word-count helper for the RX FIFO write sequencer.
package rx_seq_pkg;
  localparam int MAX_CH_DEF    = 8;
  localparam int PKT_WORDS_DEF = 256;
  localparam int TAG_CH0_BIT   = 17;
  localparam int TAG_IQ_BIT    = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_t;

  // FIFO words per sample set; channel counts above max_ch are clamped first.
  function automatic logic [3:0] calc_words(input logic       pack8,
                                            input logic [3:0] channels,
                                            input logic [3:0] max_ch);
    logic [3:0] ch;
    ch = (channels > max_ch) ? max_ch : channels;
    return pack8 ? ((ch + 4'd1) >> 1) : ch;
  endfunction
endpackage

// File: rtl/rx_fifo_sequencer_if.sv
// Strobe/FIFO-control/debug bundle between the RX sample path and the write sequencer.
interface rx_fifo_sequencer_if;
  logic        rxstrobe;
  logic [3:0]  channels;
  logic        pack8;
  logic        fifo_full;
  logic        clear_status;
  logic        cap_en;
  logic        wrreq;
  logic [3:0]  word_sel;
  logic        ch0_tag;
  logic        iq_tag;
  logic        busy;
  logic        overrun;
  logic [15:0] drop_count;
  logic [7:0]  pkt_pos;
  logic        pkt_last;

  modport master (
    output rxstrobe, channels, pack8, fifo_full, clear_status,
    input  cap_en, wrreq, word_sel, ch0_tag, iq_tag, busy, overrun,
           drop_count, pkt_pos, pkt_last
  );

  modport slave (
    input  rxstrobe, channels, pack8, fifo_full, clear_status,
    output cap_en, wrreq, word_sel, ch0_tag, iq_tag, busy, overrun,
           drop_count, pkt_pos, pkt_last
  );
endinterface

// File: rtl/rx_fifo_sequencer_pkt_counter.sv
// Word position within the current USB packet; flags the write that completes a packet.
module rx_pkt_counter
  import rx_seq_pkg::*;
#(
  parameter int PKT_WORDS = PKT_WORDS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_write,
  output logic [7:0] o_pkt_pos,
  output logic       o_pkt_last
);
  localparam logic [7:0] LAST_POS = 8'(PKT_WORDS - 1);

  logic [7:0] r_pkt_pos;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pkt_pos <= 8'd0;
    end else if (i_write) begin
      r_pkt_pos <= (r_pkt_pos == LAST_POS) ? 8'd0 : r_pkt_pos + 8'd1;
    end
  end

  assign o_pkt_pos  = r_pkt_pos;
  assign o_pkt_last = i_write & (r_pkt_pos == LAST_POS);
endmodule

// File: rtl/rx_fifo_sequencer.sv
// RX FIFO write-side sequencer: captures a sample set per strobe and emits one FIFO write per word.
module rx_fifo_sequencer
  import rx_seq_pkg::*;
#(
  parameter int MAX_CH    = MAX_CH_DEF,
  parameter int PKT_WORDS = PKT_WORDS_DEF
) (
  input  logic               rxclk,
  input  logic               reset,
  rx_fifo_sequencer_if.slave bus
);
  seq_state_t  r_state;
  seq_state_t  w_state_next;
  logic [3:0]  r_word_sel;
  logic [3:0]  w_word_sel_next;
  logic [3:0]  r_n_words;
  logic [3:0]  w_n_words_next;
  logic        r_overrun;
  logic [15:0] r_drop_count;

  logic        w_strobe_ok;
  logic        w_write;
  logic        w_last;
  logic        w_accept;
  logic        w_drop;
  logic [3:0]  w_n_words_in;

  assign w_strobe_ok  = bus.rxstrobe & (bus.channels != 4'd0);
  assign w_n_words_in = calc_words(bus.pack8, bus.channels, 4'(MAX_CH));
  assign w_write      = (r_state == ST_RUN) & ~bus.fifo_full;
  assign w_last       = w_write & (r_word_sel == r_n_words);
  // A strobe landing on the final write chains straight into the next set.
  assign w_accept     = w_strobe_ok & ((r_state == ST_IDLE) | w_last);
  assign w_drop       = bus.rxstrobe & (r_state == ST_RUN) & ~w_last;

  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_word_sel <= 4'd0;
      r_n_words  <= 4'd0;
    end else begin
      r_state    <= w_state_next;
      r_word_sel <= w_word_sel_next;
      r_n_words  <= w_n_words_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_word_sel_next = r_word_sel;
    w_n_words_next  = r_n_words;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next    = ST_RUN;
          w_word_sel_next = 4'd1;
          w_n_words_next  = w_n_words_in;
        end
      end
      ST_RUN: begin
        if (w_write) begin
          if (w_last) begin
            if (w_accept) begin
              w_word_sel_next = 4'd1;
              w_n_words_next  = w_n_words_in;
            end else begin
              w_state_next    = ST_IDLE;
              w_word_sel_next = 4'd0;
            end
          end else begin
            w_word_sel_next = r_word_sel + 4'd1;
          end
        end
      end
      default: begin
        w_state_next    = ST_IDLE;
        w_word_sel_next = 4'd0;
      end
    endcase
  end

  // A new drop outranks a simultaneous clear so no overrun goes unreported.
  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      r_overrun    <= 1'b0;
      r_drop_count <= 16'd0;
    end else begin
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (bus.clear_status) begin
        r_overrun <= 1'b0;
      end
      if (w_drop && (r_drop_count != 16'hFFFF)) begin
        r_drop_count <= r_drop_count + 16'd1;
      end
    end
  end

  assign bus.cap_en     = w_accept;
  assign bus.wrreq      = w_write;
  assign bus.word_sel   = r_word_sel;
  assign bus.ch0_tag    = (r_state == ST_RUN) & (r_word_sel == 4'd1);
  assign bus.iq_tag     = r_word_sel[0];
  assign bus.busy       = (r_state == ST_RUN);
  assign bus.overrun    = r_overrun;
  assign bus.drop_count = r_drop_count;

  rx_pkt_counter #(
    .PKT_WORDS (PKT_WORDS)
  ) u_pkt_counter (
    .clk        (rxclk),
    .rst        (reset),
    .i_write    (w_write),
    .o_pkt_pos  (bus.pkt_pos),
    .o_pkt_last (bus.pkt_last)
  );
endmodule

// File: tb/tb_rx_fifo_sequencer.sv
// Directed bench for rx_fifo_sequencer with a write scoreboard and packet-position model.
module tb_rx_fifo_sequencer;
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rx_fifo_sequencer_if bus();

  rx_fifo_sequencer #(
    .MAX_CH    (8),
    .PKT_WORDS (256)
  ) dut (
    .rxclk (clk),
    .reset (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] ws;
    logic       ch0;
    logic       iq;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         n_checks = 0;
  int         n_bad = 0;
  int         n_writes = 0;
  int         n_pkt_last = 0;
  int         writes_since_rst = 0;
  int         last_pulse_idx = 0;
  int         w_base = 0;
  logic [7:0] m_pos = 8'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  function automatic int exp_words(input int ch, input bit pk);
    int c;
    c = (ch > 8) ? 8 : ch;
    return pk ? (c + 1) / 2 : c;
  endfunction

  task automatic push_set(input int n);
    for (int k = 1; k <= n; k++) begin
      exp_t e;
      e.ws  = 4'(k);
      e.ch0 = (k == 1);
      e.iq  = k[0];
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle(input string tag);
    int guard;
    guard = 0;
    while ((bus.busy === 1'b1) && (guard < 100)) begin
      tick();
      settle();
      guard++;
    end
    chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
    chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard monitor: every issued write is matched against the expected word stream.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        m_pos            = 8'd0;
        writes_since_rst = 0;
      end else if (bus.wrreq === 1'b1) begin
        n_writes++;
        writes_since_rst++;
        chk("wr_pkt_pos", 32'(bus.pkt_pos), 32'(m_pos));
        chk("wr_pkt_last", 32'(bus.pkt_last), 32'(m_pos == 8'd255));
        if (bus.pkt_last === 1'b1) begin
          n_pkt_last++;
          last_pulse_idx = writes_since_rst;
        end
        m_pos = m_pos + 8'd1;
        if (exp_q.size() == 0) begin
          chk("sb_extra_write", 32'(bus.wrreq), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_word_sel", 32'(bus.word_sel), 32'(mon_e.ws));
          chk("sb_ch0_tag", 32'(bus.ch0_tag), 32'(mon_e.ch0));
          chk("sb_iq_tag", 32'(bus.iq_tag), 32'(mon_e.iq));
        end
        $display("write %0d: word_sel=%0d ch0=%0b iq=%0b pkt_pos=%0d pkt_last=%0b",
                 n_writes, bus.word_sel, bus.ch0_tag, bus.iq_tag, bus.pkt_pos, bus.pkt_last);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst              = 1'b1;
    bus.rxstrobe     = 1'b0;
    bus.channels     = 4'd0;
    bus.pack8        = 1'b0;
    bus.fifo_full    = 1'b0;
    bus.clear_status = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    settle();
    chk("rst_word_sel", 32'(bus.word_sel), 32'd0);
    chk("rst_wrreq", 32'(bus.wrreq), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_overrun", 32'(bus.overrun), 32'd0);
    chk("rst_drop_count", 32'(bus.drop_count), 32'd0);
    chk("rst_pkt_pos", 32'(bus.pkt_pos), 32'd0);
    chk("rst_pkt_last", 32'(bus.pkt_last), 32'd0);
    rst = 1'b0;

    // channels == 0 strobe is ignored
    tick(); bus.rxstrobe = 1'b1; bus.channels = 4'd0; settle();
    chk("zero_ch_cap_en", 32'(bus.cap_en), 32'd0);
    tick(); bus.rxstrobe = 1'b0; settle();
    chk("zero_ch_busy", 32'(bus.busy), 32'd0);
    chk("zero_ch_overrun", 32'(bus.overrun), 32'd0);

    // 4 channels, 16-bit mode, single strobe
    tick(); bus.rxstrobe = 1'b1; bus.channels = 4'd4; bus.pack8 = 1'b0;
    push_set(exp_words(4, 0)); settle();
    chk("t1_cap_en", 32'(bus.cap_en), 32'd1);
    chk("t1_wrreq_t0", 32'(bus.wrreq), 32'd0);
    tick(); bus.rxstrobe = 1'b0; bus.channels = 4'd1; settle();
    chk("t1_busy_t1", 32'(bus.busy), 32'd1);
    chk("t1_word_sel_t1", 32'(bus.word_sel), 32'd1);
    chk("t1_ch0_t1", 32'(bus.ch0_tag), 32'd1);
    tick(); settle();
    chk("t1_ch0_t2", 32'(bus.ch0_tag), 32'd0);
    chk("t1_word_sel_t2", 32'(bus.word_sel), 32'd2);
    tick(); tick(); settle();
    chk("t1_word_sel_t4", 32'(bus.word_sel), 32'd4);
    chk("t1_wrreq_t4", 32'(bus.wrreq), 32'd1);
    tick(); settle();
    chk("t1_busy_t5", 32'(bus.busy), 32'd0);
    chk("t1_word_sel_t5", 32'(bus.word_sel), 32'd0);
    chk("t1_drain", 32'(exp_q.size()), 32'd0);

    // 3 channels packed -> 2 words
    tick(); bus.rxstrobe = 1'b1; bus.channels = 4'd3; bus.pack8 = 1'b1;
    push_set(exp_words(3, 1)); settle();
    chk("t2_cap_en", 32'(bus.cap_en), 32'd1);
    tick(); bus.rxstrobe = 1'b0; bus.pack8 = 1'b0; settle();
    chk("t2_iq_t1", 32'(bus.iq_tag), 32'd1);
    wait_idle("t2");

    // channels above MAX_CH clamp to 8 words
    tick(); bus.rxstrobe = 1'b1; bus.channels = 4'd12; bus.pack8 = 1'b0;
    push_set(exp_words(12, 0)); settle();
    tick(); bus.rxstrobe = 1'b0; settle();
    wait_idle("clamp");

    // FIFO full for 5 cycles from the second word
    w_base = n_writes;
    tick(); bus.rxstrobe = 1'b1; bus.channels = 4'd2;
    push_set(exp_words(2, 0)); settle();
    tick(); bus.rxstrobe = 1'b0; settle();
    tick(); bus.fifo_full = 1'b1; settle();
    chk("t3_full_wrreq", 32'(bus.wrreq), 32'd0);
    chk("t3_full_word_sel", 32'(bus.word_sel), 32'd2);
    for (int c = 0; c < 4; c++) begin
      tick(); settle();
      chk("t3_hold_wrreq", 32'(bus.wrreq), 32'd0);
      chk("t3_hold_word_sel", 32'(bus.word_sel), 32'd2);
    end
    tick(); bus.fifo_full = 1'b0; settle();
    chk("t3_resume_wrreq", 32'(bus.wrreq), 32'd1);
    chk("t3_resume_word_sel", 32'(bus.word_sel), 32'd2);
    tick(); settle();
    chk("t3_busy_end", 32'(bus.busy), 32'd0);
    chk("t3_write_count", 32'(n_writes - w_base), 32'd2);
    chk("t3_overrun", 32'(bus.overrun), 32'd0);

    // strobe every 2 cycles, 2 channels: back-to-back sets
    for (int s = 0; s < 5; s++) begin
      tick(); bus.rxstrobe = 1'b1; bus.channels = 4'd2;
      push_set(exp_words(2, 0)); settle();
      chk("t4_cap_en", 32'(bus.cap_en), 32'd1);
      if (s > 0) chk("t4_wrreq_even", 32'(bus.wrreq), 32'd1);
      tick(); bus.rxstrobe = 1'b0; settle();
      chk("t4_wrreq_odd", 32'(bus.wrreq), 32'd1);
    end
    tick(); settle();
    chk("t4_wrreq_last", 32'(bus.wrreq), 32'd1);
    wait_idle("t4");
    chk("t4_overrun", 32'(bus.overrun), 32'd0);
    chk("t4_drop_count", 32'(bus.drop_count), 32'd0);

    // strobe every cycle, 4 channels: accepted at t and t+4, six drops
    for (int c = 0; c < 8; c++) begin
      tick(); bus.rxstrobe = 1'b1; bus.channels = 4'd4;
      if ((c == 0) || (c == 4)) push_set(exp_words(4, 0));
      settle();
      chk("t5_cap_en", 32'(bus.cap_en), 32'((c == 0) || (c == 4)));
    end
    tick(); bus.rxstrobe = 1'b0; settle();
    chk("t5_drop_count", 32'(bus.drop_count), 32'd6);
    chk("t5_overrun_set", 32'(bus.overrun), 32'd1);
    tick(); settle();
    chk("t5_idle", 32'(bus.busy), 32'd0);
    tick(); bus.clear_status = 1'b1; settle();
    tick(); bus.clear_status = 1'b0; settle();
    chk("t5_overrun_cleared", 32'(bus.overrun), 32'd0);
    tick(); bus.rxstrobe = 1'b1; bus.channels = 4'd4;
    push_set(exp_words(4, 0)); settle();
    tick(); bus.clear_status = 1'b1; settle();
    chk("t5_drop_cap_en", 32'(bus.cap_en), 32'd0);
    tick(); bus.rxstrobe = 1'b0; bus.clear_status = 1'b0; settle();
    chk("t5_set_wins", 32'(bus.overrun), 32'd1);
    chk("t5_drop_count_7", 32'(bus.drop_count), 32'd7);
    wait_idle("t5");

    // asynchronous reset at word_sel == 3
    tick(); bus.rxstrobe = 1'b1; bus.channels = 4'd4;
    push_set(exp_words(4, 0)); settle();
    tick(); bus.rxstrobe = 1'b0;
    tick(); tick(); settle();
    chk("t6_word_sel_3", 32'(bus.word_sel), 32'd3);
    rst = 1'b1;
    #1;
    chk("t6_async_wrreq", 32'(bus.wrreq), 32'd0);
    chk("t6_async_busy", 32'(bus.busy), 32'd0);
    chk("t6_async_word_sel", 32'(bus.word_sel), 32'd0);
    chk("t6_async_drop", 32'(bus.drop_count), 32'd0);
    chk("t6_async_overrun", 32'(bus.overrun), 32'd0);
    exp_q.delete();
    tick(); tick(); rst = 1'b0;

    // 256 writes from reset: pkt_last on write 256, pkt_pos wraps
    n_pkt_last = 0;
    for (int k = 0; k < 64; k++) begin
      tick(); bus.rxstrobe = 1'b1; bus.channels = 4'd4;
      push_set(exp_words(4, 0)); settle();
      chk("t7_cap_en", 32'(bus.cap_en), 32'd1);
      tick(); bus.rxstrobe = 1'b0; settle();
      if (k == 0) chk("t7_first_ch0", 32'(bus.ch0_tag), 32'd1);
      tick(); tick();
    end
    tick(); settle();
    chk("t7_pkt_pos_255", 32'(bus.pkt_pos), 32'd255);
    chk("t7_pkt_last", 32'(bus.pkt_last), 32'd1);
    tick(); settle();
    chk("t7_pkt_pos_wrap", 32'(bus.pkt_pos), 32'd0);
    chk("t7_pkt_last_count", 32'(n_pkt_last), 32'd1);
    chk("t7_pkt_last_index", 32'(last_pulse_idx), 32'd256);
    wait_idle("t7");

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
